// File: rtl/system_clk_enables.sv
// system_clk_enables: lock supervisor, system reset release and N_CH reprogrammable clock-enable strobes
module system_clk_enables #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_WAIT   = 1024,
    parameter int DIV_DEFAULT = 99
) (
    input  logic                   clk_in,
    input  logic                   reset_n,
    input  logic                   mmcm_locked,
    input  logic [N_CH*DIV_W-1:0]  div_cfg,
    input  logic [N_CH-1:0]        cfg_mask,
    input  logic                   cfg_load,
    input  logic                   sync_req,
    output logic [N_CH-1:0]        ce,
    output logic                   rst_out_n,
    output logic [7:0]             lost_cnt,
    output logic [1:0]             state
);
    localparam int SW = $clog2(LOCK_WAIT);

    typedef enum logic [1:0] {ST_WAIT = 2'd0, ST_SETTLE = 2'd1, ST_RUN = 2'd2} state_t;

    state_t           r_state, w_next;
    logic             r_lock_meta, r_lock_s;
    logic [SW-1:0]    r_settle;
    logic             r_rst_n;
    logic [7:0]       r_lost;
    logic             w_run;
    logic [DIV_W-1:0] r_cnt [N_CH];
    logic [DIV_W-1:0] r_shd [N_CH];
    logic [DIV_W-1:0] r_act [N_CH];
    logic             r_ce  [N_CH];

    // Channels only count while running with lock still present, so a lock-loss cycle behaves like idle
    assign w_run     = (r_state == ST_RUN) && r_lock_s;
    assign rst_out_n = r_rst_n;
    assign lost_cnt  = r_lost;
    assign state     = r_state;

    // Two-flop synchroniser for the asynchronous MMCM lock
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= mmcm_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Next-state logic: wait for lock, let it settle, run until lock drops
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT:   w_next = r_lock_s ? ST_SETTLE : ST_WAIT;
            ST_SETTLE: w_next = !r_lock_s ? ST_WAIT : (r_settle == SW'(LOCK_WAIT - 1)) ? ST_RUN : ST_SETTLE;
            ST_RUN:    w_next = r_lock_s ? ST_RUN : ST_WAIT;
            default:   w_next = ST_WAIT;
        endcase
    end

    // State register, settle counter, registered reset output and saturating lock-loss counter
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_WAIT;
            r_settle <= '0;
            r_rst_n  <= 1'b0;
            r_lost   <= 8'd0;
        end else begin
            r_state  <= w_next;
            r_settle <= (r_state == ST_SETTLE) ? r_settle + 1'b1 : '0;
            r_rst_n  <= (w_next == ST_RUN);
            if (r_state == ST_RUN && !r_lock_s && r_lost != 8'hFF)
                r_lost <= r_lost + 8'd1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic w_wrap;
        assign w_wrap = (r_cnt[i] == r_act[i]);
        // Per-channel shadow/active divide and counter; new divides are adopted only at a wrap
        always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt[i] <= '0;
                r_shd[i] <= DIV_W'(DIV_DEFAULT);
                r_act[i] <= DIV_W'(DIV_DEFAULT);
                r_ce[i]  <= 1'b0;
            end else begin
                if (cfg_load && cfg_mask[i])
                    r_shd[i] <= div_cfg[i*DIV_W +: DIV_W];
                if (!w_run) begin
                    r_cnt[i] <= '0;
                    r_act[i] <= r_shd[i];
                    r_ce[i]  <= 1'b0;
                end else begin
                    r_ce[i]  <= w_wrap && !sync_req;
                    r_cnt[i] <= (w_wrap || sync_req) ? '0 : r_cnt[i] + 1'b1;
                    if (w_wrap && !sync_req)
                        r_act[i] <= r_shd[i];
                end
            end
        end
    end

    // Pack the per-channel strobes onto the output vector
    always_comb begin
        ce = '0;
        for (int k = 0; k < N_CH; k++)
            ce[k] = r_ce[k];
    end
endmodule

// File: tb/tb_system_clk_enables.sv
// tb_system_clk_enables: directed checks of lock release, lock loss, divide ratios, reprogramming, sync and reset
module tb_system_clk_enables;
    logic        clk_in;
    logic        reset_n;
    logic        mmcm_locked;
    logic [63:0] div_cfg;
    logic [3:0]  cfg_mask;
    logic        cfg_load;
    logic        sync_req;
    logic [3:0]  ce;
    logic        rst_out_n;
    logic [7:0]  lost_cnt;
    logic [1:0]  state;

    int n_pass  = 0;
    int n_total = 0;

    system_clk_enables #(.N_CH(4), .DIV_W(16), .LOCK_WAIT(16), .DIV_DEFAULT(99)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .mmcm_locked(mmcm_locked),
        .div_cfg(div_cfg), .cfg_mask(cfg_mask), .cfg_load(cfg_load), .sync_req(sync_req),
        .ce(ce), .rst_out_n(rst_out_n), .lost_cnt(lost_cnt), .state(state)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; mmcm_locked = 1'b0; cfg_load = 1'b0; sync_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic load_cfg(input logic [3:0] m, input logic [63:0] v);
        cfg_mask = m; div_cfg = v; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic go_run();
        int n = 0;
        mmcm_locked = 1'b1;
        while (state !== 2'd2 && n < 60) begin tick(); n++; end
        n_total++;
        if (state !== 2'd2) $display("FAIL go_run: state %0d required 2", state); else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mmcm_locked = 1'b0; div_cfg = '0; cfg_mask = '0; cfg_load = 1'b0; sync_req = 1'b0;
        #2;
        n_total++; if (ce !== 4'h0) $display("FAIL reset_ce: got %h required 0", ce); else n_pass++;
        n_total++; if (rst_out_n !== 1'b0) $display("FAIL reset_rst: got %b required 0", rst_out_n); else n_pass++;
        n_total++; if (lost_cnt !== 8'd0) $display("FAIL reset_lost: got %0d required 0", lost_cnt); else n_pass++;
        n_total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d required 0", state); else n_pass++;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_lock_release();
        logic [1:0] es;
        mmcm_locked = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            tick();
            es = (e < 2) ? 2'd0 : (e < 18) ? 2'd1 : 2'd2;
            n_total++; if (state !== es) $display("FAIL release_state e=%0d: got %0d required %0d", e, state, es); else n_pass++;
            n_total++; if (rst_out_n !== (e >= 18)) $display("FAIL release_rst e=%0d: got %b required %b", e, rst_out_n, e >= 18); else n_pass++;
            n_total++; if (ce !== 4'h0) $display("FAIL release_ce e=%0d: got %h required 0", e, ce); else n_pass++;
        end
    endtask

    task automatic test_lock_loss();
        mmcm_locked = 1'b0;
        for (int e = 0; e <= 2; e++) begin
            tick();
            n_total++; if (rst_out_n !== (e < 2)) $display("FAIL loss_rst e=%0d: got %b required %b", e, rst_out_n, e < 2); else n_pass++;
            n_total++; if (state !== ((e < 2) ? 2'd2 : 2'd0)) $display("FAIL loss_state e=%0d: got %0d", e, state); else n_pass++;
            n_total++; if (lost_cnt !== ((e < 2) ? 8'd0 : 8'd1)) $display("FAIL loss_cnt e=%0d: got %0d", e, lost_cnt); else n_pass++;
        end
    endtask

    task automatic test_settle_abort();
        int n = 0;
        do_reset();
        mmcm_locked = 1'b1;
        repeat (5) tick();
        n_total++; if (state !== 2'd1) $display("FAIL abort_pre: state %0d required 1", state); else n_pass++;
        mmcm_locked = 1'b0;
        tick();
        mmcm_locked = 1'b1;
        while (state !== 2'd0 && n < 6) begin tick(); n++; end
        n_total++; if (state !== 2'd0) $display("FAIL abort_wait: state %0d required 0", state); else n_pass++;
        for (int k = 1; k <= 17; k++) begin
            tick();
            n_total++;
            if (state !== ((k < 17) ? 2'd1 : 2'd2)) $display("FAIL abort_resettle k=%0d: state %0d", k, state); else n_pass++;
        end
        n_total++; if (lost_cnt !== 8'd0) $display("FAIL abort_lost: got %0d required 0", lost_cnt); else n_pass++;
        n_total++; if (rst_out_n !== 1'b1) $display("FAIL abort_rst: got %b required 1", rst_out_n); else n_pass++;
    endtask

    task automatic test_lost_saturate();
        int n;
        for (int i = 0; i < 300; i++) begin
            mmcm_locked = 1'b0;
            n = 0;
            while (state !== 2'd0 && n < 8) begin tick(); n++; end
            n_total++;
            if (lost_cnt !== ((i + 1 > 255) ? 8'd255 : 8'(i + 1)))
                $display("FAIL lost_sat i=%0d: got %0d", i, lost_cnt);
            else n_pass++;
            go_run();
        end
    endtask

    task automatic test_ratios();
        int c3 = 0;
        logic [2:0] e;
        do_reset();
        load_cfg(4'hF, {16'd65535, 16'd4, 16'd1, 16'd0});
        go_run();
        n_total++; if (ce !== 4'h0) $display("FAIL ratio_k0: got %h required 0", ce); else n_pass++;
        for (int k = 1; k <= 65536; k++) begin
            tick();
            if (k <= 40) begin
                e = {k % 5 == 0, k % 2 == 0, 1'b1};
                n_total++; if (ce[2:0] !== e) $display("FAIL ratio k=%0d: got %b required %b", k, ce[2:0], e); else n_pass++;
            end
            if (k < 65536) c3 += int'(ce[3]);
            else begin
                n_total++; if (ce[3] !== 1'b1) $display("FAIL ratio_ch3_first: got %b required 1", ce[3]); else n_pass++;
            end
        end
        n_total++; if (c3 !== 0) $display("FAIL ratio_ch3_early: got %0d pulses required 0", c3); else n_pass++;
    endtask

    task automatic test_reprogram(input int lk, input int s);
        logic e0, e1;
        do_reset();
        load_cfg(4'h3, {16'd99, 16'd99, 16'd4, 16'd9});
        go_run();
        cfg_mask = 4'h1;
        div_cfg  = {16'd99, 16'd99, 16'd7, 16'd2};
        for (int k = 0; k <= 45; k++) begin
            if (k > 0) tick();
            cfg_load = (k == lk);
            e0 = (k > 0 && k <= s && k % 10 == 0) || (k > s && (k - s) % 3 == 0);
            e1 = (k > 0 && k % 5 == 0);
            n_total++; if (ce[0] !== e0) $display("FAIL reprog%0d_ch0 k=%0d: got %b required %b", lk, k, ce[0], e0); else n_pass++;
            n_total++; if (ce[1] !== e1) $display("FAIL reprog%0d_ch1 k=%0d: got %b required %b", lk, k, ce[1], e1); else n_pass++;
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_sync();
        logic e0, e1;
        do_reset();
        load_cfg(4'h3, {16'd99, 16'd99, 16'd7, 16'd3});
        go_run();
        for (int k = 0; k <= 48; k++) begin
            if (k > 0) tick();
            sync_req = (k == 15);
            e0 = (k <= 15) ? (k > 0 && k % 4 == 0) : (k > 16 && (k - 16) % 4 == 0);
            e1 = (k <= 15) ? (k > 0 && k % 8 == 0) : (k > 16 && (k - 16) % 8 == 0);
            n_total++; if (ce[0] !== e0) $display("FAIL sync_ch0 k=%0d: got %b required %b", k, ce[0], e0); else n_pass++;
            n_total++; if (ce[1] !== e1) $display("FAIL sync_ch1 k=%0d: got %b required %b", k, ce[1], e1); else n_pass++;
        end
        sync_req = 1'b0;
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset();
        go_run();
        mmcm_locked = 1'b0;
        while (state !== 2'd0 && n < 8) begin tick(); n++; end
        load_cfg(4'h1, {16'd99, 16'd99, 16'd99, 16'd3});
        go_run();
        repeat (4) tick();
        n_total++; if (ce[0] !== 1'b1) $display("FAIL areset_pre_ce: got %b required 1", ce[0]); else n_pass++;
        n_total++; if (lost_cnt !== 8'd1) $display("FAIL areset_pre_lost: got %0d required 1", lost_cnt); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (ce !== 4'h0) $display("FAIL areset_ce: got %h required 0", ce); else n_pass++;
        n_total++; if (rst_out_n !== 1'b0) $display("FAIL areset_rst: got %b required 0", rst_out_n); else n_pass++;
        n_total++; if (lost_cnt !== 8'd0) $display("FAIL areset_lost: got %0d required 0", lost_cnt); else n_pass++;
        n_total++; if (state !== 2'd0) $display("FAIL areset_state: got %0d required 0", state); else n_pass++;
        tick();
        reset_n = 1'b1;
        go_run();
        for (int k = 1; k <= 100; k++) begin
            tick();
            n_total++; if (ce[0] !== (k == 100)) $display("FAIL areset_div k=%0d: got %b required %b", k, ce[0], k == 100); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lock_release();
        test_lock_loss();
        test_settle_abort();
        test_lost_saturate();
        test_ratios();
        test_reprogram(13, 20);
        test_reprogram(19, 30);
        test_sync();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/system_clk_enables.md
# system_clk_enables

Parametrised clock-enable and reset supervisor downstream of the carrier's MMCM clock block. Runs on the MMCM output clock, watches the MMCM `locked` status, holds a synchronous system reset until lock has been stable for a programmable settle time, then generates N_CH independent, glitch-free, runtime-reprogrammable clock-enable strobes. It also counts lock-loss events. It replaces fixed MMCM output dividers for slow timing domains (ADC frame, trigger, housekeeping ticks).

## Interface
- `N_CH`, default 4: number of clock-enable channels (1..16).
- `DIV_W`, default 16: width of each divide value.
- `LOCK_WAIT`, default 1024: number of cycles `locked` must stay stable before release (≥2).
- `DIV_DEFAULT`, default 99: reset divide value for all channels (ratio = value+1).

- `clk_in`: input, 1 bit. System clock (MMCM output). Only clock.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `mmcm_locked`: input, 1 bit. MMCM lock, asynchronous to `clk_in`; 2-FF synchronised internally.
- `div_cfg`: input, N_CH*DIV_W bits. Channel i divide value in bits [i*DIV_W +: DIV_W].
- `cfg_mask`: input, N_CH bits. Channels updated on `cfg_load`.
- `cfg_load`: input, 1 bit. One-cycle strobe; latches masked `div_cfg` slices into shadow registers.
- `sync_req`: input, 1 bit. One-cycle strobe; realigns all channel counters to 0.
- `ce`: output, N_CH bits. Registered one-cycle enable strobes.
- `rst_out_n`: output, 1 bit. Registered synchronous active-low system reset.
- `lost_cnt`: output, 8 bits. Saturating count of lock losses while running.
- `state`: output, 2 bits. FSM state: 0 WAIT, 1 SETTLE, 2 RUN.

## Operation
- **Reset values:** `ce`=0, `rst_out_n`=0, `lost_cnt`=0, `state`=WAIT, settle counter 0, channel counters 0, shadow and active divides = `DIV_DEFAULT`.
- **Lock sync:** `locked_s` is `mmcm_locked` after 2 flops. All FSM decisions use `locked_s`.
- **FSM transitions:**
  - WAIT → SETTLE when `locked_s`=1. Settle counter cleared.
  - SETTLE: the counter increments each cycle.
    - If `locked_s`=0, go to WAIT.
    - Else when the counter reaches LOCK_WAIT-1, go to RUN.
  - RUN → WAIT when `locked_s`=0. `lost_cnt` increments and saturates at 255. It never wraps.
- **rst_out_n:** registered from next_state==RUN. It is high exactly while `state`==RUN and drops in the same cycle `state` leaves RUN.
- **Channel counters:** outside RUN, every `cnt[i]` is held at 0, `ce`=0, and `div_act[i]` ← `div_shd[i]` continuously.
- **In RUN:**
  - `cnt[i]` increments.
  - When `cnt[i]`==`div_act[i]` (the wrap), `cnt[i]` ← 0 and `div_act[i]` ← `div_shd[i]`.
  - `ce[i]` is registered: `ce[i]` ← (RUN && `cnt[i]`==`div_act[i]` && !`sync_req`).
- **Divide ratio** = `div_act`+1. A divide of 0 gives `ce[i]` high every RUN cycle after the first.
- **cfg_load:** `div_shd[i]` ← slice i for every i with `cfg_mask[i]`=1; unmasked channels are unchanged. The new value takes effect at that channel's next wrap, so no shortened or stretched period occurs.
  - If `cfg_load` coincides with a wrap, the wrap copies the old shadow. The new value is adopted at the following wrap.
- **sync_req in RUN:** all `cnt` ← 0 and `ce` is suppressed for that cycle. `div_act` is not reloaded. `sync_req` is ignored outside RUN.
- **Simultaneous `sync_req` and lock loss:** lock loss wins.
- **Mid-operation `reset_n` assertion:** every output returns to its reset value immediately (asynchronously).

## Timing
- Lock-to-release: with `mmcm_locked` rising before edge 0, `rst_out_n` rises LOCK_WAIT+3 cycles later (2 sync + 1 WAIT→SETTLE + LOCK_WAIT settle).
- Lock loss to `rst_out_n` low: 3 cycles (2 sync + 1).
- First `ce[i]` pulse: RUN cycle `div_act`+1, counting the first RUN cycle as 0. Thereafter every `div_act`+1 cycles.
- After `sync_req` at RUN cycle t: next `ce[i]` at t+`div_act`+2. All channels with equal divides are then phase-aligned.
- `cfg_load` to shadow: 1 cycle.

## Test plan
- **Lock release:** LOCK_WAIT=16, `mmcm_locked` 0→1 → `state` goes WAIT→SETTLE→RUN, `rst_out_n` rises exactly 19 cycles later, `ce` stays 0 before that.
- **Settle abort:** drop `mmcm_locked` for 1 cycle during SETTLE → `state` returns to WAIT, settle restarts, `lost_cnt` stays 0. Drop it in RUN 300 times → `lost_cnt`=255.
- **Ratios:** divides 0, 1, 4, 65535 on ch0..3 → `ce` periods of 1, 2, 5, 65536 cycles. First pulses at RUN cycles 1, 2, 5, 65536.
- **Glitch-free reprogram:** ch0 at divide 9, `cfg_load` with mask 0001 and new value 2 mid-period → current 10-cycle period completes, then 3-cycle periods. Other channels unchanged. Repeat with `cfg_load` on a wrap cycle → one extra 10-cycle period.
- **Sync:** ch0 divide 3, ch1 divide 7, `sync_req` at arbitrary phase → no `ce` that cycle. Next `ce` pulses at t+5 and t+9. Thereafter coincident every 8 cycles.
- **Async reset mid-RUN:** assert `reset_n` low → all outputs reset immediately, divides return to 99.
